// File: rtl/ee354_project_pkg.sv
// Shared direction encoding for the snake game datapath.
// Used by the direction controller, the length DPU and the VGA renderer.
// Pure declarations: no latency, no flow control.
package ee354_project_pkg;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_LEFT  = 2'b10;
  localparam logic [1:0] DIR_RIGHT = 2'b11;

  // Two directions are opposite when they share an axis (bit 1) but differ in sense (bit 0).
  function automatic logic is_reverse(input logic [1:0] a, input logic [1:0] b);
    return (a[1] == b[1]) && (a[0] != b[0]);
  endfunction

endpackage

// File: rtl/ee354_project_turn_fifo.sv
// Small synchronous FIFO of pending 2-bit turn directions.
// Latency: push visible on count/newest the cycle after the edge; head is combinational from storage.
// Backpressure: a push into a full queue is ignored unless a pop happens on the same edge.
module ee354_project_turn_fifo
  import ee354_project_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     flush,
  input  logic                     push,
  input  logic [1:0]               push_dir,
  input  logic                     pop,
  output logic [1:0]               head,
  output logic [1:0]               newest,
  output logic [$clog2(QDEPTH):0]  count,
  output logic                     full,
  output logic                     empty
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [1:0]    mem [QDEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW-1:0] newest_ptr;
  logic          push_ok;
  logic          pop_ok;

  assign full       = (count == CW'(QDEPTH));
  assign empty      = (count == '0);
  assign newest_ptr = wr_ptr - PW'(1);
  assign head       = mem[rd_ptr];
  assign newest     = mem[newest_ptr];

  // A pop frees a slot on the same edge, so a full queue can still take a push then.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);

  // Pointer and occupancy bookkeeping; pointers wrap naturally since QDEPTH is a power of 2.
  always_ff @(posedge clk) begin
    if (reset || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PW'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // Entry storage; contents are only meaningful below count, so no reset is needed.
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= push_dir;
  end

endmodule

// File: rtl/ee354_project_dirn_ctrl.sv
// Button-to-direction front end: queued, reversal-filtered turns plus the move tick (Speed_Clk).
// Latency: Speed_Clk one cycle after the counter wraps; Curr_Dirn updates on the same edge as Speed_Clk rises.
// Backpressure: none upstream; a valid turn arriving at a full queue without a pop is dropped and flagged on Turn_Drop.
// Optional SPEEDUP_EN: move period shrinks with snake Length, clamped at MIN_PERIOD.
module ee354_project_dirn_ctrl
  import ee354_project_pkg::*;
#(
  parameter int BASE_PERIOD = 25_000_000,
  parameter int MIN_PERIOD  = 6_250_000,
  parameter int STEP        = 500_000,
  parameter int QDEPTH      = 2,
  parameter int CNT_W       = 26
) (
  input  logic                     Clk,
  input  logic                     Reset,
  input  logic                     q_Run,
  input  logic                     BtnU,
  input  logic                     BtnD,
  input  logic                     BtnL,
  input  logic                     BtnR,
  input  logic [7:0]               Length,
  output logic                     Speed_Clk,
  output logic [1:0]               Curr_Dirn,
  output logic                     Turn_Drop,
  output logic [$clog2(QDEPTH):0]  Q_Count
);

  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] period;
  logic [CNT_W-1:0] next_period;
  logic             run_d;
  logic             wrap;

  logic             press_vld;
  logic [1:0]       press_dir;
  logic [1:0]       ref_dir;
  logic             accept;
  logic             pop;
  logic             drop;

  logic [1:0]       fifo_head;
  logic [1:0]       fifo_newest;
  logic             fifo_full;
  logic             fifo_empty;

  // The interval ends when the counter reaches the last count of the latched period.
  assign wrap = q_Run && (counter == period - CNT_W'(1));
  assign pop  = wrap && !fifo_empty;

  // Pick a single press with fixed priority U > D > L > R.
  always_comb begin
    press_vld = BtnU | BtnD | BtnL | BtnR;
    press_dir = DIR_UP;
    if (BtnU)      press_dir = DIR_UP;
    else if (BtnD) press_dir = DIR_DOWN;
    else if (BtnL) press_dir = DIR_LEFT;
    else if (BtnR) press_dir = DIR_RIGHT;
  end

  // Filter against the direction the snake will be heading when this turn executes.
  always_comb begin
    ref_dir = fifo_empty ? Curr_Dirn : fifo_newest;
    accept  = q_Run && press_vld && (press_dir != ref_dir) && !is_reverse(press_dir, ref_dir);
    drop    = accept && fifo_full && !pop;
  end

`ifdef SPEEDUP_EN
  logic [31:0] len32;
  logic [31:0] dec32;
  logic [31:0] per32;

  // Shorten the move period by STEP per segment past 3, never below MIN_PERIOD.
  always_comb begin
    len32 = (Length < 8'd3) ? 32'd3 : {24'd0, Length};
    dec32 = (len32 - 32'd3) * 32'(STEP);
    if ((dec32 >= 32'(BASE_PERIOD)) || ((32'(BASE_PERIOD) - dec32) < 32'(MIN_PERIOD)))
      per32 = 32'(MIN_PERIOD);
    else
      per32 = 32'(BASE_PERIOD) - dec32;
    next_period = per32[CNT_W-1:0];
  end
`else
  // Fixed-speed build: Length has no effect on the tick.
  logic unused_length;
  assign unused_length = ^Length;
  assign next_period   = CNT_W'(BASE_PERIOD);
`endif

  // Latch the period only at interval boundaries so a Length change never stretches a move in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      period <= CNT_W'(BASE_PERIOD);
      run_d  <= 1'b0;
    end else begin
      run_d <= q_Run;
      if (q_Run && (!run_d || wrap)) period <= next_period;
    end
  end

  // Move-interval counter; parked at zero while the game is not running.
  always_ff @(posedge Clk) begin
    if (Reset || !q_Run || wrap) counter <= '0;
    else                         counter <= counter + CNT_W'(1);
  end

  // Registered tick and drop pulses, plus the committed direction updated with the tick.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      Speed_Clk <= 1'b0;
      Turn_Drop <= 1'b0;
      Curr_Dirn <= DIR_UP;
    end else begin
      Speed_Clk <= wrap;
      Turn_Drop <= drop;
      if (pop) Curr_Dirn <= fifo_head;
    end
  end

  ee354_project_turn_fifo #(
    .QDEPTH (QDEPTH)
  ) u_turn_fifo (
    .clk      (Clk),
    .reset    (Reset),
    .flush    (!q_Run),
    .push     (accept),
    .push_dir (press_dir),
    .pop      (pop),
    .head     (fifo_head),
    .newest   (fifo_newest),
    .count    (Q_Count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

endmodule
